// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - Wishbone master command encoding shared by the core and the bus master
package wb_pkg;

    typedef enum logic [1:0] {
        WISHBONE_CMD_NONE  = 2'd0,
        WISHBONE_CMD_LOAD  = 2'd1,
        WISHBONE_CMD_STORE = 2'd2
    } wb_command_t;

endpackage

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding RV32I load/store unit driving a word-aligned Wishbone master
module load_store_unit
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        req_valid_in,
    input  logic        req_store_in,
    input  logic [2:0]  req_funct3_in,
    input  logic [31:0] req_addr_in,
    input  logic [31:0] req_wdata_in,
    output logic        busy_out,
    output logic        done_out,
    output logic [31:0] rdata_out,
    output logic [1:0]  fault_out,
    output wb_command_t cmd_out,
    input  logic        master_busy_in,
    input  logic [31:0] master_rdata_in,
    output logic [31:0] addr_out,
    output logic [31:0] wdata_out,
    output logic [3:0]  wmask_out
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE, S_FAULT
    } state_t;

    state_t      state_q;
    logic        done_q;
    logic [1:0]  fault_q;
    logic [31:0] rdata_q;
    wb_command_t cmd_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;
    logic [31:0] cnt_q;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;

    logic        legal_d;
    logic        misaligned_d;
    logic [31:0] wdata_d;
    logic [3:0]  wmask_d;
    logic [31:0] ld_shift;
    logic [31:0] ld_data_d;
    logic [31:0] cnt_d;
    logic        timeout_hit;

    always_comb begin
        legal_d = req_store_in ? (req_funct3_in inside {3'b000, 3'b001, 3'b010})
                               : (req_funct3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        case (req_funct3_in[1:0])
            2'b01:   misaligned_d = req_addr_in[0];
            2'b10:   misaligned_d = (req_addr_in[1:0] != 2'b00);
            default: misaligned_d = 1'b0;
        endcase
        case (req_funct3_in[1:0])
            2'b00: begin
                wdata_d = {4{req_wdata_in[7:0]}};
                wmask_d = 4'b0001 << req_addr_in[1:0];
            end
            2'b01: begin
                wdata_d = {2{req_wdata_in[15:0]}};
                wmask_d = 4'b0011 << req_addr_in[1:0];
            end
            default: begin
                wdata_d = req_wdata_in;
                wmask_d = 4'b1111;
            end
        endcase
    end

    // Load data is formatted from the request latched at accept time, not the live req_* inputs.
    always_comb begin
        ld_shift = master_rdata_in >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ld_data_d = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data_d = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_data_d = {24'd0, ld_shift[7:0]};
            3'b101:  ld_data_d = {16'd0, ld_shift[15:0]};
            default: ld_data_d = ld_shift;
        endcase
        cnt_d       = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_d >= TIMEOUT_CYCLES);
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q  <= S_IDLE;
            done_q   <= 1'b0;
            fault_q  <= 2'b00;
            rdata_q  <= 32'd0;
            cmd_q    <= WISHBONE_CMD_NONE;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            wmask_q  <= 4'd0;
            cnt_q    <= 32'd0;
            store_q  <= 1'b0;
            funct3_q <= 3'd0;
            off_q    <= 2'd0;
        end else begin
            cmd_q  <= WISHBONE_CMD_NONE;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // The cycle carrying the done pulse is IDLE but still refuses new work.
                    if (req_valid_in && !done_q) begin
                        store_q  <= req_store_in;
                        funct3_q <= req_funct3_in;
                        off_q    <= req_addr_in[1:0];
                        if (!legal_d) begin
                            fault_q <= 2'b10;
                            state_q <= S_FAULT;
                        end else if (misaligned_d) begin
                            fault_q <= 2'b01;
                            state_q <= S_FAULT;
                        end else begin
                            fault_q <= 2'b00;
                            state_q <= S_ISSUE;
                            cmd_q   <= req_store_in ? WISHBONE_CMD_STORE : WISHBONE_CMD_LOAD;
                            addr_q  <= {req_addr_in[31:2], 2'b00};
                            wdata_q <= req_store_in ? wdata_d : 32'd0;
                            wmask_q <= req_store_in ? wmask_d : 4'b0000;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= 32'd0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (!master_busy_in) begin
                        if (!store_q) begin
                            rdata_q <= ld_data_d;
                        end
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                        if (timeout_hit) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!master_busy_in) begin
                        fault_q <= 2'b11;
                        state_q <= S_FAULT;
                    end
                end
                S_DONE, S_FAULT: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_out  = (state_q != S_IDLE);
    assign done_out  = done_q;
    assign fault_out = fault_q;
    assign rdata_out = rdata_q;
    assign cmd_out   = cmd_q;
    assign addr_out  = addr_q;
    assign wdata_out = wdata_q;
    assign wmask_out = wmask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit against a request-level model
module tb_load_store_unit;
    import wb_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic [1:0]  fault_o;
    wb_command_t cmd_o;
    logic        mbusy = 1'b0;
    logic [31:0] mrdata = 32'd0;
    logic [31:0] addr_o;
    logic [31:0] wdata_o;
    logic [3:0]  wmask_o;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cmd_cnt = 0;
    logic [31:0] exp_rdata = 32'd0;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_in(clk), .reset_in(reset_n),
        .req_valid_in(req_valid), .req_store_in(req_store), .req_funct3_in(req_funct3),
        .req_addr_in(req_addr), .req_wdata_in(req_wdata),
        .busy_out(busy_o), .done_out(done_o), .rdata_out(rdata_o), .fault_out(fault_o),
        .cmd_out(cmd_o), .master_busy_in(mbusy), .master_rdata_in(mrdata),
        .addr_out(addr_o), .wdata_out(wdata_o), .wmask_out(wmask_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_o != WISHBONE_CMD_NONE) cmd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int off, input logic [31:0] word);
        logic [31:0] v;
        logic [31:0] b;
        v = word >> (8 * off);
        case (f3)
            3'd0: begin b = v & 32'hFF;   return (b >= 32'd128)   ? b - 32'd256   : b; end
            3'd1: begin b = v & 32'hFFFF; return (b >= 32'd32768) ? b - 32'd65536 : b; end
            3'd4: return v & 32'hFF;
            3'd5: return v & 32'hFFFF;
            default: return v;
        endcase
    endfunction

    task automatic run_txn(input string tag, input bit st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] d,
                           input int n_busy, input logic [31:0] word);
        bit   legal;
        bit   mis;
        int   size;
        int   efault;
        bit   issued;
        int   lat;
        int   c0;
        logic [31:0] ewdata;
        logic [3:0]  ewmask;
        legal  = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size   = 1 << f3[1:0];
        mis    = (addr % size) != 0;
        efault = !legal ? 2 : mis ? 1 : (n_busy >= TMO) ? 3 : 0;
        issued = (efault == 0 || efault == 3);
        case (f3[1:0])
            2'd0: begin ewdata = (d & 32'hFF) * 32'h0101_0101;   ewmask = 4'(1 << addr[1:0]); end
            2'd1: begin ewdata = (d & 32'hFFFF) * 32'h0001_0001; ewmask = 4'(3 << addr[1:0]); end
            default: begin ewdata = d; ewmask = 4'hF; end
        endcase

        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = addr; req_wdata = d;
        c0 = cmd_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        check({tag, " busy"}, 32'(busy_o), 32'd1);
        if (issued) begin
            check({tag, " cmd"}, 32'(cmd_o), st ? 32'(WISHBONE_CMD_STORE) : 32'(WISHBONE_CMD_LOAD));
            check({tag, " addr"}, addr_o, addr & 32'hFFFF_FFFC);
            if (st) begin
                check({tag, " wdata"}, wdata_o, ewdata);
                check({tag, " wmask"}, 32'(wmask_o), 32'(ewmask));
            end else begin
                check({tag, " wmask"}, 32'(wmask_o), 32'd0);
            end
        end

        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (done_o) begin
                lat = k;
                break;
            end
            if (issued && k == 1) begin
                mbusy = 1'b1;
                mrdata = $urandom;
            end
            if (issued && k == n_busy + 1) begin
                mbusy = 1'b0;
                mrdata = word;
            end
        end
        mbusy = 1'b0;
        check({tag, " latency"}, 32'(lat), issued ? 32'(n_busy + 3) : 32'd1);
        check({tag, " fault"}, 32'(fault_o), 32'(efault));
        if (efault == 0 && !st) exp_rdata = model_load(f3, int'(addr[1:0]), word);
        check({tag, " rdata"}, rdata_o, exp_rdata);
        check({tag, " cmd count"}, 32'(cmd_cnt - c0), issued ? 32'd1 : 32'd0);
        @(posedge clk);
        #1;
        check({tag, " done width"}, 32'(done_o), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst done", 32'(done_o), 32'd0);
        check("rst fault", 32'(fault_o), 32'd0);
        check("rst rdata", rdata_o, 32'd0);
        check("rst cmd", 32'(cmd_o), 32'(WISHBONE_CMD_NONE));
        check("rst addr", addr_o, 32'd0);
        check("rst wdata", wdata_o, 32'd0);
        check("rst wmask", 32'(wmask_o), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        run_txn("sw", 1'b1, 3'd2, 32'h104, 32'hDEAD_BEEF, 2, 32'h0);
        run_txn("sb", 1'b1, 3'd0, 32'h103, 32'h0000_00A5, 1, 32'h0);
        run_txn("lb", 1'b0, 3'd0, 32'h202, 32'h0, 3, 32'h12F4_5678);
        check("lb value", rdata_o, 32'hFFFF_FFF4);
        run_txn("lbu", 1'b0, 3'd4, 32'h202, 32'h0, 1, 32'h12F4_5678);
        check("lbu value", rdata_o, 32'h0000_00F4);
        run_txn("lhu", 1'b0, 3'd5, 32'h202, 32'h0, 2, 32'h12F4_5678);
        check("lhu value", rdata_o, 32'h0000_12F4);
        run_txn("lw mis", 1'b0, 3'd2, 32'h3, 32'h0, 1, 32'h0);
        run_txn("ld f3=011", 1'b0, 3'd3, 32'h0, 32'h0, 1, 32'h0);
        run_txn("sh f3=100", 1'b1, 3'd4, 32'h0, 32'h0, 1, 32'h0);
        run_txn("tmo", 1'b0, 3'd2, 32'h400, 32'h0, 10, 32'hCAFE_F00D);
        run_txn("tmo edge", 1'b0, 3'd2, 32'h404, 32'h0, TMO, 32'h1111_2222);
        run_txn("tmo below", 1'b0, 3'd2, 32'h408, 32'h0, TMO - 1, 32'h3333_4444);

        // Abandon a load in WAIT with an asynchronous reset.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        mbusy = 1'b1;
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst busy", 32'(busy_o), 32'd0);
        check("arst rdata", rdata_o, 32'd0);
        check("arst addr", addr_o, 32'd0);
        check("arst cmd", 32'(cmd_o), 32'(WISHBONE_CMD_NONE));
        exp_rdata = 32'd0;
        mbusy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("arst no done", 32'(done_o), 32'd0);
        end
        reset_n = 1'b1;
        run_txn("post rst", 1'b0, 3'd1, 32'h2, 32'h0, 2, 32'h8001_0000);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run_txn("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
                    $urandom, int'($urandom_range(1, 6)), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
